// File: rtl/cond_flag_unit.sv
// cond_flag_unit: masked ALU flag register with shadow flag stack, driving the microsequencer condition bus.
// Optional loop counter on conditional_wires[8] is built when COND_LOOP_COUNTER_EN is defined.
module cond_flag_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  flag_update,
  input  logic [3:0]            flag_we,
  input  logic                  flag_push,
  input  logic                  flag_pop,
  input  logic                  cnt_load,
  input  logic [CNT_WIDTH-1:0]  cnt_value,
  input  logic                  cnt_dec,
  output logic [3:0]            flags,
  output logic [8:0]            conditional_wires,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_err
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [3:0]    stack [STACK_DEPTH];
  logic [DW-1:0] depth, depth_next;
  logic [AW-1:0] top, widx;
  logic [3:0]    alu_flags, base, mask, flags_next;
  logic          do_push, do_pop, xchg, bad, stack_we, cnt_zero;
  assign stack_empty = depth == '0;
  assign stack_full  = depth == DW'(STACK_DEPTH);
  assign top         = AW'(depth - 1'b1);
  assign alu_flags   = {alu_overflow, alu_carry, alu_result[DATA_WIDTH-1], alu_result == '0};
  always_comb begin
    xchg       = flag_push & flag_pop & !stack_empty;
    bad        = (flag_push & flag_pop) ? stack_empty : flag_push ? stack_full : flag_pop & stack_empty;
    do_push    = flag_push & !flag_pop & !stack_full;
    do_pop     = flag_pop & !flag_push & !stack_empty;
    base       = (do_pop | xchg) ? stack[top] : flags;
    mask       = flag_update ? flag_we : 4'h0;
    flags_next = (base & ~mask) | (alu_flags & mask);
    depth_next = do_push ? depth + 1'b1 : do_pop ? depth - 1'b1 : depth;
    stack_we   = do_push | xchg;
    widx       = xchg ? top : AW'(depth);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'h0;
      depth     <= '0;
      stack_err <= 1'b0;
    end else begin
      flags     <= flags_next;
      depth     <= depth_next;
      stack_err <= stack_err | bad;
    end
  end
  // Entries above depth are never read, so contents need no reset.
  always_ff @(posedge clk) begin
    if (stack_we && !reset) stack[widx] <= flags;
  end
`ifdef COND_LOOP_COUNTER_EN
  logic [CNT_WIDTH-1:0] loop_cnt;
  always_ff @(posedge clk) begin
    if (reset) loop_cnt <= '0;
    else if (cnt_load) loop_cnt <= cnt_value;
    else if (cnt_dec && loop_cnt != '0) loop_cnt <= loop_cnt - 1'b1;
  end
  assign cnt_zero = loop_cnt == '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_load, cnt_dec, cnt_value};
  assign cnt_zero   = 1'b0;
`endif
  assign conditional_wires = {cnt_zero, ~flags[2] | flags[0], flags[1] ^ flags[3], flags[3],
                              flags[2], flags[1], ~flags[0], flags[0], 1'b1};
endmodule

// File: doc/cond_flag_unit.md
# cond_flag_unit

Producer of the 9-bit `conditional_wires` bus consumed by the microsequencer's status selection mux. It latches ALU flags (Z, N, C, V) under a per-flag write mask and keeps a small shadow stack of saved flags for microcode subroutines and interrupt entry. It also holds an optional microcode loop counter. From these registered flags it derives the fixed condition encoding indexed by the 4-bit `cc` field of the microinstruction.

## Interface
- DATA_WIDTH, 16, ALU result width
- STACK_DEPTH, 4, shadow flag stack entries (≥1)
- CNT_WIDTH, 8, loop counter width
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- alu_result  in  DATA_WIDTH  ALU result for Z/N derivation
- alu_carry  in  1  ALU carry-out
- alu_overflow  in  1  ALU signed overflow
- flag_update  in  1  capture strobe
- flag_we  in  4  per-flag write mask {V,C,N,Z}, qualified by flag_update
- flag_push  in  1  push current flags onto shadow stack
- flag_pop  in  1  restore flags from shadow stack top
- cnt_load  in  1  load loop counter
- cnt_value  in  CNT_WIDTH  loop counter load value
- cnt_dec  in  1  decrement loop counter
- flags  out  4  registered {V,C,N,Z}
- conditional_wires  out  9  condition bus, index = cc code
- stack_empty  out  1  no entries held
- stack_full  out  1  STACK_DEPTH entries held
- stack_err  out  1  sticky overflow/underflow error

## Operation
- Flag derivation: Z = (alu_result == 0); N = alu_result[DATA_WIDTH-1]; C = alu_carry; V = alu_overflow.
- Update: on flag_update, each flag with flag_we bit = 1 takes its new value. Other flags hold.
- conditional_wires, combinational from registered state:
  - [0] = 1
  - [1] = Z
  - [2] = !Z
  - [3] = N
  - [4] = C
  - [5] = V
  - [6] = N^V
  - [7] = !C | Z
  - [8] = (loop_cnt == 0)
- Push: writes the current registered flags (pre-update value in the same cycle) to the stack top. Depth increments by 1.
- Pop: flags take the top entry. Depth decrements by 1.
- Pop with flag_update in the same cycle: popped value first, then masked bits are overwritten by the update, per bit.
- Push and pop together, not empty: exchange. Flags take the top entry, the top entry takes the current flags, depth is unchanged.
- Push and pop together while empty: error, no state change.
- Push when full: ignored, stack_err set.
- Pop when empty: ignored, stack_err set.
- stack_err clears only on reset.
- Loop counter: cnt_load has priority over cnt_dec. Decrement saturates at 0, with no wrap.

## Timing
- All state updates on the rising clk edge. conditional_wires, flags and status outputs reflect an event in the cycle after it.
- Latency from flag_update to a visible condition: 1 cycle. The microsequencer must not branch on a flag in the same cycle it is updated.
- Reset values: flags = 4'b0000, loop_cnt = 0, stack depth = 0, stack_empty = 1, stack_full = 0, stack_err = 0.
- conditional_wires at reset: 9'h185 with COND_LOOP_COUNTER_EN, 9'h085 without.
- Reset asserted mid-operation overrides every strobe in that cycle. Stack contents are discarded (depth = 0).
- STACK_DEPTH = 1: stack_full and !stack_empty are equal after one push.

## Configuration
- COND_LOOP_COUNTER_EN defined:
  - loop counter instantiated
  - conditional_wires[8] = (loop_cnt == 0)
- COND_LOOP_COUNTER_EN undefined:
  - no counter registers
  - cnt_load, cnt_dec and cnt_value ignored
  - conditional_wires[8] tied 0
- Everything else is identical in both builds.

## Test plan
- Reset, then idle → flags = 0, conditional_wires = 9'h185 (macro on) or 9'h085 (macro off), stack_empty = 1.
- flag_update, flag_we = 4'hF, alu_result = 16'h8000, carry = 1, overflow = 0 → next cycle flags = {V0,C1,N1,Z0}, conditional_wires[6] = 1, [7] = 0, [2] = 1.
- flag_we = 4'b0001 with alu_result = 0 after the state above → only Z = 1; N and C retained; conditional_wires[7] = 1.
- Push 4 times with distinct flags (STACK_DEPTH = 4), fifth push → stack_full = 1, stack_err = 1, depth unchanged. Then 4 pops restore flags in LIFO order and stack_empty = 1.
- Pop while empty, then push and pop together while empty → stack_err = 1, flags unchanged. Exchange with 1 entry (top = 4'hA, flags = 4'h5) → flags = 4'hA, top = 4'h5, depth 1.
- Macro on: cnt_load = 3, then cnt_dec for 5 cycles → [8] goes 1 only after the 3rd decrement and stays 1 (saturates). cnt_load and cnt_dec together with value 2 → loop_cnt = 2.
